// File: rtl/hilo_pkg.sv
// Shared constants for the HI/LO multiply/divide sequencer: ALU opcodes,
// FSM state encoding, iteration count and the divide-by-zero LO pattern.
package hilo_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int HILO_STEPS = 32;

  localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/hilo_step.sv
// One iteration of shift-add multiply or restoring divide around an external ALU.
// The divide path exists only when HILO_DIV_EN is defined.
module hilo_step
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] acc_hi_next,
  output logic [WIDTH-1:0] acc_lo_next,
  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b
);

`ifdef HILO_DIV_EN
  // Partial remainder shifted left by one; bit WIDTH is the overflow msb.
  logic [WIDTH:0] rem_shift;
  logic           accept;
  assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign accept    = rem_shift[WIDTH] || (rem_shift[WIDTH-1:0] >= opnd);
`else
  logic unused_op_div;
  assign unused_op_div = op_div;
`endif

  // Unsigned overflow of the ADD shows up as a wrapped, smaller sum.
  logic carry;
  assign carry = (alu_result < acc_hi);

  always_comb begin
    alu_operation = ALU_ADD;
    alu_a         = acc_hi;
    alu_b         = acc_lo[0] ? opnd : '0;
    acc_hi_next   = {carry, alu_result[WIDTH-1:1]};
    acc_lo_next   = {alu_result[0], acc_lo[WIDTH-1:1]};
`ifdef HILO_DIV_EN
    if (op_div) begin
      alu_operation = ALU_SUB;
      alu_a         = rem_shift[WIDTH-1:0];
      alu_b         = opnd;
      acc_hi_next   = accept ? alu_result : rem_shift[WIDTH-1:0];
      acc_lo_next   = {acc_lo[WIDTH-2:0], accept};
    end
`endif
  end

endmodule

// File: rtl/hilo_sequencer.sv
// Multi-cycle MULTU/DIVU controller driving a shared ALU one step per clock.
// Define HILO_DIV_EN to build the DIVU path; otherwise DIVU completes as a no-op.
module hilo_sequencer
  import hilo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = HILO_STEPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_div,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result
);

  localparam int SW = $clog2(STEPS);
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  state_t           state_reg;
  logic [SW-1:0]    step_reg;
  logic             op_div_reg;
  logic [WIDTH-1:0] acc_hi_reg;
  logic [WIDTH-1:0] acc_lo_reg;
  logic [WIDTH-1:0] opnd_reg;

  logic [WIDTH-1:0] acc_hi_next;
  logic [WIDTH-1:0] acc_lo_next;
  logic [3:0]       step_operation;
  logic [WIDTH-1:0] step_a;
  logic [WIDTH-1:0] step_b;

  hilo_step #(.WIDTH(WIDTH)) u_step (
    .op_div       (op_div_reg),
    .acc_hi       (acc_hi_reg),
    .acc_lo       (acc_lo_reg),
    .opnd         (opnd_reg),
    .alu_result   (alu_result),
    .acc_hi_next  (acc_hi_next),
    .acc_lo_next  (acc_lo_next),
    .alu_operation(step_operation),
    .alu_a        (step_a),
    .alu_b        (step_b)
  );

  // The ALU is only borrowed while iterating; otherwise it sees a quiet AND 0,0.
  assign alu_operation = (state_reg == RUN) ? step_operation : ALU_AND;
  assign alu_a         = (state_reg == RUN) ? step_a : '0;
  assign alu_b         = (state_reg == RUN) ? step_b : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      step_reg   <= '0;
      op_div_reg <= 1'b0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      opnd_reg   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            op_div_reg <= op_div;
            step_reg   <= '0;
            busy       <= 1'b1;
            if (!op_div) begin
              acc_hi_reg <= '0;
              acc_lo_reg <= rt_data;
              opnd_reg   <= rs_data;
              state_reg  <= RUN;
            end else begin
`ifdef HILO_DIV_EN
              if (rt_data != '0) begin
                acc_hi_reg <= '0;
                acc_lo_reg <= rs_data;
                opnd_reg   <= rt_data;
                state_reg  <= RUN;
              end else begin
                hi        <= rs_data;
                lo        <= DIV0_LO[WIDTH-1:0];
                done      <= 1'b1;
                state_reg <= DONE;
              end
`else
              done      <= 1'b1;
              state_reg <= DONE;
`endif
            end
          end
        end
        RUN: begin
          acc_hi_reg <= acc_hi_next;
          acc_lo_reg <= acc_lo_next;
          step_reg   <= step_reg + 1'b1;
          if (step_reg == LAST_STEP) begin
            hi        <= acc_hi_next;
            lo        <= acc_lo_next;
            done      <= 1'b1;
            step_reg  <= '0;
            state_reg <= DONE;
          end
        end
        DONE: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef HILO_DIV_EN
  // Sticky flag: cleared by any accepted start, set by a zero divisor.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div0 <= 1'b0;
    end else if (state_reg == IDLE && start) begin
      div0 <= op_div && (rt_data == '0);
    end
  end
`else
  assign div0 = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_sequencer.sv
// Self-checking bench for hilo_sequencer: per-cycle comparison against an
// arithmetic reference model, directed cases and randomized operations.
module tb_hilo_sequencer;

  localparam int STEPS = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op_div = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;
  logic [3:0]  alu_operation;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_result;

  int tests = 0;
  int fails = 0;

  hilo_sequencer #(.WIDTH(32), .STEPS(STEPS)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .op_div       (op_div),
    .rs_data      (rs_data),
    .rt_data      (rt_data),
    .busy         (busy),
    .done         (done),
    .div0         (div0),
    .hi           (hi),
    .lo           (lo),
    .alu_operation(alu_operation),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_result   (alu_result)
  );

  always #5 clk = ~clk;

  // Team ALU subset: ADD, SUB, AND.
  always_comb begin
    case (alu_operation)
      4'b0011: alu_result = alu_a + alu_b;
      4'b0100: alu_result = alu_a - alu_b;
      default: alu_result = alu_a & alu_b;
    endcase
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an operation is a countdown of known latency whose result
  // is plain arithmetic, published in its last cycle.
  logic        m_busy = 1'b0, m_done = 1'b0, m_div0 = 1'b0;
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [31:0] r_hi = '0, r_lo = '0;
  logic        r_div0 = 1'b0;
  int          m_cnt = 0, m_lat = 0;
  bit          m_apply = 1'b0, m_isdiv = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 0; m_done = 0; m_div0 = 0; m_hi = '0; m_lo = '0;
      m_cnt = 0; m_lat = 0; m_apply = 0; m_isdiv = 0;
    end else begin
      if (m_cnt == 0) begin
        if (start) begin
          m_cnt   = 1;
          m_isdiv = op_div;
          m_div0  = 0;
          m_apply = 1;
          r_div0  = 0;
          if (!op_div) begin
            m_lat = STEPS + 1;
            {r_hi, r_lo} = {32'b0, rs_data} * {32'b0, rt_data};
          end
`ifdef HILO_DIV_EN
          else if (rt_data == 0) begin
            m_lat = 1; r_hi = rs_data; r_lo = 32'hFFFF_FFFF; r_div0 = 1;
          end else begin
            m_lat = STEPS + 1; r_hi = rs_data % rt_data; r_lo = rs_data / rt_data;
          end
`else
          else begin
            m_lat = 1; m_apply = 0;
          end
`endif
        end
      end else if (m_cnt == m_lat) begin
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
      m_busy = (m_cnt != 0);
      m_done = m_busy && (m_cnt == m_lat);
      if (m_done && m_apply) begin
        m_hi = r_hi; m_lo = r_lo; m_div0 = r_div0;
      end
    end
  end

  always @(posedge clk) begin
    logic [3:0] m_op;
    #1;
    m_op = 4'b0000;
    if (m_busy && !m_done && m_lat == STEPS + 1) m_op = m_isdiv ? 4'b0100 : 4'b0011;
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    check("div0", 64'(div0), 64'(m_div0));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
    check("alu_operation", 64'(alu_operation), 64'(m_op));
    if (m_op == 4'b0000) begin
      check("alu_a_idle", 64'(alu_a), 64'd0);
      check("alu_b_idle", 64'(alu_b), 64'd0);
    end
  end

  // Waits (bounded) for done; cyc is the cycle number done was seen in.
  task automatic wait_done(input int cyc0, input bit noise, output int cyc);
    cyc = cyc0;
    while (!done && cyc < 100) begin
      if (noise) begin
        start   = ($urandom_range(0, 2) == 0);
        op_div  = $urandom_range(0, 1) == 1;
        rs_data = $urandom;
        rt_data = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
    end
    @(negedge clk);
  endtask

  task automatic do_op(input bit d, input logic [31:0] a, input logic [31:0] b,
                       input bit noise, output int lat);
    start = 1'b1; op_div = d; rs_data = a; rt_data = b;
    @(negedge clk);
    start = 1'b0;
    wait_done(1, noise, lat);
    $display("[TB] %s rs=%08h rt=%08h -> hi=%08h lo=%08h div0=%0b done_cycle=%0d",
             d ? "DIVU " : "MULTU", a, b, hi, lo, div0, lat);
  endtask

  initial begin
    int lat;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    @(negedge clk);

    do_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat);
    check("mul_max_lat", 64'(lat), 64'd33);
    check("mul_max_hi", 64'(hi), 64'hFFFF_FFFE);
    check("mul_max_lo", 64'(lo), 64'h1);

`ifdef HILO_DIV_EN
    do_op(1, 32'd100, 32'd7, 0, lat);
    check("div_100_7_lo", 64'(lo), 64'd14);
    check("div_100_7_hi", 64'(hi), 64'd2);
    do_op(1, 32'hFFFF_FFFF, 32'h10, 0, lat);
    check("div_big_lo", 64'(lo), 64'h0FFF_FFFF);
    check("div_big_hi", 64'(hi), 64'hF);
    do_op(1, 32'h1234, 32'd0, 0, lat);
    check("div0_lat", 64'(lat), 64'd1);
    check("div0_flag", 64'(div0), 64'd1);
    check("div0_hi", 64'(hi), 64'h1234);
    check("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    do_op(0, 32'd3, 32'd5, 0, lat);
    check("div0_cleared", 64'(div0), 64'd0);
    check("mul_3_5_lo", 64'(lo), 64'd15);
`endif

    // MULTU 6x7 with an ignored start (9x9) at cycle 10
    start = 1'b1; op_div = 1'b0; rs_data = 32'd6; rt_data = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    start = 1'b1; rs_data = 32'd9; rt_data = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done(11, 0, lat);
    $display("[TB] MULTU rs=00000006 rt=00000007 (9x9 restart ignored) -> hi=%08h lo=%08h done_cycle=%0d", hi, lo, lat);
    check("mul_6_7_lat", 64'(lat), 64'd33);
    check("mul_6_7_lo", 64'(lo), 64'd42);
    check("mul_6_7_hi", 64'(hi), 64'd0);

    // Abort a MULTU with reset at cycle 12
    start = 1'b1; op_div = 1'b0; rs_data = 32'hFFFF; rt_data = 32'hFFFF;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_alu_op", 64'(alu_operation), 64'd0);
    check("abort_alu_a", 64'(alu_a), 64'd0);
    $display("[TB] reset abort at cycle 12 -> busy=%0b hi=%08h lo=%08h", busy, hi, lo);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(0, 32'd2, 32'd3, 0, lat);
    check("mul_2_3_lat", 64'(lat), 64'd33);
    check("mul_2_3_lo", 64'(lo), 64'd6);

    do_op(1, 32'd9, 32'd3, 0, lat);
`ifdef HILO_DIV_EN
    check("div_9_3_lat", 64'(lat), 64'd33);
    check("div_9_3_lo", 64'(lo), 64'd3);
    check("div_9_3_hi", 64'(hi), 64'd0);
`else
    check("nodiv_lat", 64'(lat), 64'd1);
    check("nodiv_lo", 64'(lo), 64'd6);
    check("nodiv_hi", 64'(hi), 64'd0);
    check("nodiv_div0", 64'(div0), 64'd0);
`endif

    for (int i = 0; i < 150; i++) begin
      bit          d;
      logic [31:0] a, b;
      d = $urandom_range(0, 1) == 1;
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 15);
        2: b = a >> $urandom_range(0, 8);
        default: b = $urandom;
      endcase
      do_op(d, a, b, $urandom_range(0, 1) == 1, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish by %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
